fw_loader: RTL and testbench
============================

Name: fw_loader

Overview:
- Boot-time loader that sits directly upstream of the `mem` block.
- Accepts a firmware byte stream over a valid/ready handshake and writes the bytes into consecutive memory locations starting at a programmable base.
- Then writes the 6502 reset vector (low byte, high byte) so it points at that base.
- Holds the CPU in reset until loading completes, replacing the bench-only memory override path with a synthesizable load path.

Parameters:
- ADDR_WIDTH, 16, address bus width (matches `ADDR_WIDTH`).
- REG_WIDTH, 8, data width (matches `REG_WIDTH`).
- VEC_ADDR, 16'hFFFC, address of the reset vector low byte; the high byte goes to VEC_ADDR+1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- base_addr  in  ADDR_WIDTH  first load address; captured on an accepted start.
- length  in  ADDR_WIDTH  number of bytes to load; captured on an accepted start; 0 is legal.
- s_valid  in  1  a stream byte is present.
- s_data  in  REG_WIDTH  stream byte.
- s_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  write strobe to `mem`.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_din  out  REG_WIDTH  write data.
- busy  out  1  high in LOAD, VEC_LO and VEC_HI.
- done  out  1  high in DONE.
- checksum  out  REG_WIDTH  mod-256 sum of the bytes loaded in the current or most recent load.
- cpu_reset_n  out  1  active-low reset to `cpu_top`; high only in DONE.

Behaviour:
- States: IDLE, LOAD, VEC_LO, VEC_HI, DONE (codes in the package).
- Reset: state=IDLE; s_ready=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, checksum=0, cpu_reset_n=0; internal count=0.
- IDLE or DONE with start=1:
  - capture base_addr and length; clear count and checksum.
  - go to LOAD if length!=0, otherwise go to VEC_LO.
  - cpu_reset_n drops low on the same edge when leaving DONE.
- start is ignored in LOAD, VEC_LO and VEC_HI.
- s_ready is combinational: (state==LOAD). A transfer occurs only when s_valid && s_ready. s_data is never sampled outside a transfer.
- Transfer at edge N produces, registered and valid during cycle N+1:
  - mem_we=1, mem_addr=base+count, mem_din=s_data.
  - checksum += s_data (mod 256); count++.
- Address arithmetic is mod 2^ADDR_WIDTH, so base+count wraps from FFFF to 0000. There is no overlap check against VEC_ADDR; the vector writes win because they are last.
- The transfer with count==length-1 moves the state to VEC_LO on the same edge, so s_ready is 0 in the next cycle.
- s_valid low in LOAD: stall indefinitely, mem_we=0, no timeout.
- VEC_LO (one cycle): registered write mem_addr=VEC_ADDR, mem_din=base[7:0]; then go to VEC_HI.
- VEC_HI (one cycle): registered write mem_addr=VEC_ADDR+1, mem_din=base[15:8]; then go to DONE.
- mem_we is high for exactly one cycle per write and is 0 in every other cycle.
- DONE: done=1, cpu_reset_n=1, busy=0. mem_addr and mem_din hold their last values. Stays in DONE until reset or start.
- Latency for length L: first mem_we one cycle after the first transfer. With no stalls, done rises L+3 cycles after start: L loads, 2 vector writes, 1 output register.
- Reset mid-operation (any state): return to reset values next edge. A partial load is abandoned and cpu_reset_n=0.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package (`PKG/pkg.v`) holds:
  - state encoding `define`s.
  - default VEC_ADDR (`RESET_VECTOR`).
  - `INSTRUCTION_BASE`, `ADDR_WIDTH`, `REG_WIDTH`.
- No sub-module: a single FSM plus count/checksum registers. The write-port mux (load vs vector) stays inline.

Test Plan:
- Base 0x0200, length 4, bytes A9,01,8D,00 with s_valid held high:
  - writes 0200..0203 on 4 consecutive cycles, then FFFC=00, FFFD=02.
  - checksum=0x37; done and cpu_reset_n rise 7 cycles after start.
- Same load with s_valid toggling every other cycle:
  - identical memory contents and checksum, no mem_we during stalls, done delayed by exactly the stall count.
- Length 0, base 0x8000:
  - only the two vector writes (FFFC=00, FFFD=80); checksum=0; done 3 cycles after start.
- Base 0xFFFE, length 3, bytes 11,22,33:
  - writes to FFFE, FFFF, 0000 (address wrap); vector = FE,FF.
- reset pulsed after 2 of 4 bytes:
  - all outputs return to reset values; cpu_reset_n stays 0; a new start reloads correctly from count 0.
- start pulsed during LOAD is ignored. start pulsed in DONE drops cpu_reset_n the next cycle and starts a fresh load.

Source files
------------

// File: rtl/fw_loader_pkg.sv
// Shared constants and state encoding for the firmware boot loader.
// Widths mirror the CPU/memory build; RESET_VECTOR is the 6502 reset vector low byte.
package fw_loader_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH  = 8;

  localparam logic [15:0] RESET_VECTOR     = 16'hFFFC;
  localparam logic [15:0] INSTRUCTION_BASE = 16'h0200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VEC_LO = 3'd2,
    ST_VEC_HI = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/fw_loader.sv
// Streams firmware bytes into memory from a base address, then writes the reset vector
// to point at that base; the CPU is held in reset until the image is complete.
module fw_loader #(
  parameter int ADDR_WIDTH = fw_loader_pkg::ADDR_WIDTH,
  parameter int REG_WIDTH  = fw_loader_pkg::REG_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] VEC_ADDR = fw_loader_pkg::RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  s_valid,
  input  logic [REG_WIDTH-1:0]  s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_din,
  output logic                  busy,
  output logic                  done,
  output logic [REG_WIDTH-1:0]  checksum,
  output logic                  cpu_reset_n
);
  import fw_loader_pkg::*;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q, len_q, count;
  logic                  done_q;
  logic                  start_ok, xfer, last;

  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
  assign xfer     = s_valid && s_ready;
  assign last     = (count == len_q - ADDR_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = (length != '0) ? ST_LOAD : ST_VEC_LO;
      end
      ST_LOAD:   if (xfer && last) state_nxt = ST_VEC_LO;
      ST_VEC_LO: state_nxt = ST_VEC_HI;
      ST_VEC_HI: state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state)
      ST_LOAD:              begin s_ready = 1'b1; busy = 1'b1; end
      ST_VEC_LO, ST_VEC_HI: busy = 1'b1;
      default:              ;
    endcase
  end

  // Write port and bookkeeping are registered; done lags DONE by one cycle but
  // clears on the same edge that accepts a new start.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q   <= '0;
      len_q    <= '0;
      count    <= '0;
      checksum <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      done_q   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done_q <= (state == ST_DONE) && !start;
      if (start_ok) begin
        base_q   <= base_addr;
        len_q    <= length;
        count    <= '0;
        checksum <= '0;
      end
      case (state)
        ST_LOAD: begin
          if (xfer) begin
            mem_we   <= 1'b1;
            mem_addr <= base_q + count;
            mem_din  <= s_data;
            checksum <= checksum + s_data;
            count    <= count + ADDR_WIDTH'(1);
          end
        end
        ST_VEC_LO: begin
          mem_we   <= 1'b1;
          mem_addr <= VEC_ADDR;
          mem_din  <= base_q[REG_WIDTH-1:0];
        end
        ST_VEC_HI: begin
          mem_we   <= 1'b1;
          mem_addr <= VEC_ADDR + ADDR_WIDTH'(1);
          mem_din  <= base_q[2*REG_WIDTH-1:REG_WIDTH];
        end
        default: ;
      endcase
    end
  end

  assign done        = done_q;
  assign cpu_reset_n = done_q;

endmodule

// File: tb/tb_fw_loader.sv
// Directed bench for fw_loader: captures every memory write and checks it against hand-built lists.
module tb_fw_loader;
  import fw_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, s_valid;
  logic [15:0] base_addr, length;
  logic [7:0]  s_data;
  logic        s_ready, mem_we, busy, done, cpu_reset_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din, checksum;

  int checks = 0;
  int errors = 0;

  logic [15:0] log_a [16];
  logic [7:0]  log_d [16];
  int          log_n = 0;
  logic [7:0]  bytes [8];

  fw_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done),
    .checksum(checksum), .cpu_reset_n(cpu_reset_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we && log_n < 16) begin
      log_a[log_n] = mem_addr;
      log_d[log_n] = mem_din;
      log_n++;
    end
  end

  // mode 0: s_valid always high; 1: s_valid low on even cycles; 2: stray start during LOAD
  task automatic run_load(input logic [15:0] b, input logic [15:0] l, input int mode,
                          output int e, output int stalls, output logic crn0, output logic busy0);
    int idx;
    idx = 0; stalls = 0; e = 0;
    @(negedge clk);
    log_n = 0; base_addr = b; length = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0; crn0 = cpu_reset_n; busy0 = busy;
    while (!done && e < 200) begin
      s_valid = 1'b0;
      s_data  = 8'hEE;
      if (mode == 2 && e == 1) begin
        start = 1'b1; base_addr = 16'h1234; length = 16'h0000;
      end
      if (s_ready && idx < int'(l)) begin
        if (mode == 1 && e % 2 == 0) stalls++;
        else begin
          s_valid = 1'b1; s_data = bytes[idx]; idx++;
        end
      end
      @(negedge clk);
      e++;
      start = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    base_addr = 16'h0000; length = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, mem_we, busy, done, cpu_reset_n} !== 5'b00000 || mem_addr !== 16'h0 ||
        mem_din !== 8'h0 || checksum !== 8'h0)
      begin errors++; $display("FAIL reset_state: rdy/we/busy/done/crn=%b addr=%h din=%h sum=%h required all zero",
        {s_ready, mem_we, busy, done, cpu_reset_n}, mem_addr, mem_din, checksum); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cpu_reset_n !== 1'b0)
      begin errors++; $display("FAIL idle_state: busy=%b crn=%b required 0 0", busy, cpu_reset_n); end
  endtask

  task automatic test_basic;
    logic [15:0] ea [6] = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'hFFFC, 16'hFFFD};
    logic [7:0]  ed [6] = '{8'hA9, 8'h01, 8'h8D, 8'h00, 8'h00, 8'h02};
    int e, st; logic crn0, b0;
    bytes = '{8'hA9, 8'h01, 8'h8D, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0};
    run_load(INSTRUCTION_BASE, 16'd4, 0, e, st, crn0, b0);
    checks++;
    if (e !== 7) begin errors++; $display("FAIL basic_latency: done after %0d cycles required 7", e); end
    checks++;
    if (log_n !== 6) begin errors++; $display("FAIL basic_wcount: %0d writes required 6", log_n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
        begin errors++; $display("FAIL basic_write%0d: %h=%h required %h=%h", i, log_a[i], log_d[i], ea[i], ed[i]); end
    end
    checks++;
    if (checksum !== 8'h37 || cpu_reset_n !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL basic_final: sum=%h crn=%b busy=%b required 37 1 0", checksum, cpu_reset_n, busy); end
  endtask

  task automatic test_stall_restart;
    logic [15:0] ea [6] = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'hFFFC, 16'hFFFD};
    logic [7:0]  ed [6] = '{8'hA9, 8'h01, 8'h8D, 8'h00, 8'h00, 8'h02};
    int e, st; logic crn0, b0;
    run_load(16'h0200, 16'd4, 1, e, st, crn0, b0);
    checks++;
    if (crn0 !== 1'b0 || b0 !== 1'b1)
      begin errors++; $display("FAIL restart_from_done: crn=%b busy=%b required 0 1", crn0, b0); end
    checks++;
    if (st !== 4 || e !== 11) begin errors++; $display("FAIL stall_latency: stalls=%0d done=%0d required 4 11", st, e); end
    checks++;
    if (log_n !== 6) begin errors++; $display("FAIL stall_wcount: %0d writes required 6", log_n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
        begin errors++; $display("FAIL stall_write%0d: %h=%h required %h=%h", i, log_a[i], log_d[i], ea[i], ed[i]); end
    end
    checks++;
    if (checksum !== 8'h37) begin errors++; $display("FAIL stall_sum: %h required 37", checksum); end
  endtask

  task automatic test_zero_length;
    int e, st; logic crn0, b0;
    run_load(16'h8000, 16'd0, 0, e, st, crn0, b0);
    checks++;
    if (e !== 3 || log_n !== 2)
      begin errors++; $display("FAIL zero_len: done=%0d writes=%0d required 3 2", e, log_n); end
    checks++;
    if (log_a[0] !== 16'hFFFC || log_d[0] !== 8'h00 || log_a[1] !== 16'hFFFD || log_d[1] !== 8'h80)
      begin errors++; $display("FAIL zero_vec: %h=%h %h=%h required FFFC=00 FFFD=80", log_a[0], log_d[0], log_a[1], log_d[1]); end
    checks++;
    if (checksum !== 8'h00) begin errors++; $display("FAIL zero_sum: %h required 00", checksum); end
  endtask

  task automatic test_addr_wrap;
    logic [15:0] ea [5] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFC, 16'hFFFD};
    logic [7:0]  ed [5] = '{8'h11, 8'h22, 8'h33, 8'hFE, 8'hFF};
    int e, st; logic crn0, b0;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    run_load(16'hFFFE, 16'd3, 0, e, st, crn0, b0);
    checks++;
    if (log_n !== 5 || e !== 6) begin errors++; $display("FAIL wrap_count: writes=%0d done=%0d required 5 6", log_n, e); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_a[i] !== ea[i] || log_d[i] !== ed[i])
        begin errors++; $display("FAIL wrap_write%0d: %h=%h required %h=%h", i, log_a[i], log_d[i], ea[i], ed[i]); end
    end
    checks++;
    if (checksum !== 8'h66) begin errors++; $display("FAIL wrap_sum: %h required 66", checksum); end
  endtask

  task automatic test_start_in_load;
    int e, st; logic crn0, b0;
    bytes = '{8'hA9, 8'h01, 8'h8D, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0};
    run_load(16'h0300, 16'd4, 2, e, st, crn0, b0);
    checks++;
    if (e !== 7 || log_n !== 6) begin errors++; $display("FAIL ignore_start: done=%0d writes=%0d required 7 6", e, log_n); end
    checks++;
    if (log_a[0] !== 16'h0300 || log_a[3] !== 16'h0303 || log_d[4] !== 8'h00 || log_d[5] !== 8'h03)
      begin errors++; $display("FAIL ignore_start_addr: %h %h vec %h %h required 0300 0303 vec 00 03",
        log_a[0], log_a[3], log_d[4], log_d[5]); end
  endtask

  task automatic test_reset_midload;
    int e, st; logic crn0, b0;
    @(negedge clk);
    base_addr = 16'h0200; length = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'hA9;
    @(negedge clk);
    s_data = 8'h01;
    @(negedge clk);
    s_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, mem_we, busy, done, cpu_reset_n} !== 5'b00000 || mem_addr !== 16'h0 ||
        mem_din !== 8'h0 || checksum !== 8'h0)
      begin errors++; $display("FAIL midload_reset: rdy/we/busy/done/crn=%b addr=%h din=%h sum=%h required all zero",
        {s_ready, mem_we, busy, done, cpu_reset_n}, mem_addr, mem_din, checksum); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_reset_n !== 1'b0) begin errors++; $display("FAIL midload_crn: %b required 0", cpu_reset_n); end
    bytes = '{8'hA9, 8'h01, 8'h8D, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0};
    run_load(16'h0200, 16'd4, 0, e, st, crn0, b0);
    checks++;
    if (e !== 7 || log_n !== 6 || log_a[0] !== 16'h0200 || log_d[0] !== 8'hA9 || log_a[3] !== 16'h0203)
      begin errors++; $display("FAIL reload: done=%0d writes=%0d first %h=%h fourth %h required 7 6 0200=A9 0203",
        e, log_n, log_a[0], log_d[0], log_a[3]); end
    checks++;
    if (checksum !== 8'h37 || cpu_reset_n !== 1'b1)
      begin errors++; $display("FAIL reload_final: sum=%h crn=%b required 37 1", checksum, cpu_reset_n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_restart();
    test_zero_length();
    test_addr_wrap();
    test_start_in_load();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
